// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I fetch stage. Owns the PC, drives the async instruction ROM
//            and registers the returned word into the IF/ID pipeline register.
// Option   : FETCH_PERF_CNT_EN adds fetch_cnt_o / flush_cnt_o event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [1:0]            pc_src_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic [ADDR_WIDTH-1:0] jalr_target_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4_o,
    output logic                  id_valid_o,
    output logic                  misalign_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    localparam logic [1:0]            c_src_branch = 2'b01;
    localparam logic [1:0]            c_src_jalr   = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] c_pc_step    = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_redirect;
    logic                  w_id_load;
    logic                  w_unused_jalr_lsb;

    logic [DATA_WIDTH-1:0] r_id_instr;
    logic [ADDR_WIDTH-1:0] r_id_pc;
    logic [ADDR_WIDTH-1:0] r_id_pc_plus4;
    logic                  r_id_valid;
    logic                  r_misalign;

    // JALR clears bit 0 itself, so the incoming LSB is intentionally dropped.
    assign w_unused_jalr_lsb = jalr_target_i[0];
    assign w_pc_plus4        = r_pc + c_pc_step;
    assign w_id_load         = !flush_i && !stall_i;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = branch_target_i;
        w_pc_next  = w_pc_plus4;
        case (pc_src_i)
            c_src_branch: begin
                w_redirect = 1'b1;
                w_target   = branch_target_i;
            end
            c_src_jalr: begin
                w_redirect = 1'b1;
                w_target   = {jalr_target_i[ADDR_WIDTH-1:1], 1'b0};
            end
            default: ;
        endcase
        // A redirect wins over a stall so a taken branch is never lost.
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_redirect && w_target[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_id_valid    <= 1'b0;
        end else if (flush_i) begin
            // Flush only kills the instruction; the PC fields are left as-is.
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (!stall_i) begin
            r_id_instr    <= imem_instr_i;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
            r_id_valid    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_id_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (flush_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    logic w_unused_id_load;
    assign w_unused_id_load = w_id_load;
`endif

    assign imem_addr_o   = r_pc;
    assign id_instr_o    = r_id_instr;
    assign id_pc_o       = r_id_pc;
    assign id_pc_plus4_o = r_id_pc_plus4;
    assign id_valid_o    = r_id_valid;
    assign misalign_o    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed vector table,
//            async reset sequence, randomized run against a reference model.
// Option   : FETCH_PERF_CNT_EN also checks the fetch/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [1:0]  pc_src_i;
    logic [31:0] branch_target_i;
    logic [31:0] jalr_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_valid_o;
    logic        misalign_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .pc_src_i        (pc_src_i),
        .branch_target_i (branch_target_i),
        .jalr_target_i   (jalr_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_instr_i    (imem_instr_i),
        .id_instr_o      (id_instr_o),
        .id_pc_o         (id_pc_o),
        .id_pc_plus4_o   (id_pc_plus4_o),
        .id_valid_o      (id_valid_o),
        .misalign_o      (misalign_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word address in the low bits, byte offset rotated to the top, so aligned
    // addresses give word[i]=i and misaligned fetches are still distinguishable.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[1:0], a[31:2]};
    endfunction

    assign imem_instr_i = rom(imem_addr_o);

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  src;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic f, input logic [1:0] src,
                       input logic [31:0] bt, input logic [31:0] jt,
                       input logic [31:0] addr, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] pc4,
                       input logic v, input logic m);
        vec_t t;
        t.stall = s; t.flush = f; t.src = src; t.bt = bt; t.jt = jt;
        t.addr = addr; t.instr = instr; t.pc = pc; t.pc4 = pc4;
        t.valid = v; t.mis = m;
        tbl.push_back(t);
    endtask

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic v, input logic m);
        chk(tag, "imem_addr", imem_addr_o, addr);
        chk(tag, "id_instr", id_instr_o, instr);
        chk(tag, "id_pc", id_pc_o, pc);
        chk(tag, "id_pc_plus4", id_pc_plus4_o, pc4);
        chk(tag, "id_valid", 32'(id_valid_o), 32'(v));
        chk(tag, "misalign", 32'(misalign_o), 32'(m));
    endtask

    task automatic drive(input logic s, input logic f, input logic [1:0] src,
                         input logic [31:0] bt, input logic [31:0] jt);
        stall_i = s; flush_i = f; pc_src_i = src;
        branch_target_i = bt; jalr_target_i = jt;
    endtask

    // Reference model state
    logic [31:0] m_pc, m_instr, m_id_pc, m_pc4, m_fetch, m_flush;
    logic        m_valid, m_mis;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = c_nop; m_id_pc = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0; m_fetch = 32'h0; m_flush = 32'h0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic [1:0] src,
                              input logic [31:0] bt, input logic [31:0] jt);
        logic        redirect;
        logic [31:0] tgt;
        redirect = (src == 2'd1) || (src == 2'd2);
        tgt      = (src == 2'd1) ? bt : (jt & 32'hFFFF_FFFE);
        if (f) begin
            m_instr = c_nop;
            m_valid = 1'b0;
            m_flush = m_flush + 1;
        end else if (!s) begin
            m_instr = rom(m_pc);
            m_id_pc = m_pc;
            m_pc4   = m_pc + 4;
            m_valid = 1'b1;
            m_fetch = m_fetch + 1;
        end
        m_mis = redirect && tgt[1];
        if (redirect)  m_pc = tgt;
        else if (!s)   m_pc = m_pc + 4;
    endtask

    function automatic logic [31:0] rand_tgt();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255)) << 2;
            1:       return $urandom;
            2:       return 32'hFFFF_FFFC;
            default: return (32'($urandom_range(0, 255)) << 2) | 32'h2;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Directed table: expected values are the state after each edge.
        //   s     f     src    bt            jt            addr          instr         id_pc         pc4           v     m
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h4,        32'h0,        32'h0,        32'h4,        1'b1, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h8,        32'h1,        32'h4,        32'h8,        1'b1, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h8,        32'h1,        32'h4,        32'h8,        1'b1, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h8,        32'h1,        32'h4,        32'h8,        1'b1, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'hC,        32'h2,        32'h8,        32'hC,        1'b1, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h10,       32'h3,        32'hC,        32'h10,       1'b1, 1'b0);
        add(1'b0, 1'b1, 2'b01, 32'h40,       32'h0,        32'h40,       c_nop,        32'hC,        32'h10,       1'b0, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h44,       32'h10,       32'h40,       32'h44,       1'b1, 1'b0);
        add(1'b1, 1'b0, 2'b10, 32'h0,        32'h21,       32'h20,       32'h10,       32'h40,       32'h44,       1'b1, 1'b0);
        add(1'b1, 1'b1, 2'b10, 32'h0,        32'h22,       32'h22,       c_nop,        32'h40,       32'h44,       1'b0, 1'b1);
        add(1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h22,       c_nop,        32'h40,       32'h44,       1'b0, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h26,       32'h8000_0008, 32'h22,      32'h26,       1'b1, 1'b0);
        add(1'b0, 1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, c_nop,       32'h22,       32'h26,       1'b0, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0,      1'b1, 1'b0);
        add(1'b0, 1'b0, 2'b11, 32'h80,       32'h90,       32'h4,        32'h0,        32'h0,        32'h4,        1'b1, 1'b0);
        add(1'b0, 1'b0, 2'b01, 32'h102,      32'h0,        32'h102,      32'h1,        32'h4,        32'h8,        1'b1, 1'b1);
        add(1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h106,      32'h8000_0040, 32'h102,     32'h106,      1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, c_nop, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].src, tbl[i].bt, tbl[i].jt);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].instr,
                    tbl[i].pc, tbl[i].pc4, tbl[i].valid, tbl[i].mis);
        end

        // Async reset while stalled, checked before the next rising edge.
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, c_nop, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_rst", "fetch_cnt", fetch_cnt_o, 32'h0);
        chk("async_rst", "flush_cnt", flush_cnt_o, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            logic        s, f;
            logic [1:0]  src;
            logic [31:0] bt, jt;
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 4) == 0);
            src = 2'($urandom_range(0, 3));
            bt  = rand_tgt();
            jt  = rand_tgt() | 32'($urandom_range(0, 1));
            drive(s, f, src, bt, jt);
            model_edge(s, f, src, bt, jt);
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_id_pc, m_pc4, m_valid, m_mis);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rnd%0d", i), "fetch_cnt", fetch_cnt_o, m_fetch);
            chk($sformatf("rnd%0d", i), "flush_cnt", flush_cnt_o, m_flush);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
